pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Multi-channel, parametrised pattern serializer: holds NUM_CH programmable bit patterns of up to PAT_W bits, each with its own length, and on request shifts the selected one out MSB-first on a single registered serial line. It replaces fixed dynamic/static shift-register generators in the signal-generation path. It adds run-time pattern loading, per-channel length, a start/busy/done handshake and optional looping.

## Interface
- NUM_CH, 4: number of pattern channels (≥1)
- PAT_W, 88: maximum pattern width in bits (≥2)
- PAT_INIT, 0: NUM_CH*PAT_W-bit reset image; channel c occupies bits [c*PAT_W +: PAT_W]
- CH_W, $clog2(NUM_CH) (min 1): channel index width
- CNT_W, $clog2(PAT_W+1): length/counter width
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- WR_EN  in  1  write strobe for pattern bank
- WR_CH  in  CH_W  channel written
- WR_DATA  in  PAT_W  pattern; the emitted bits are the low LEN bits, MSB (bit LEN-1) first
- WR_LEN  in  CNT_W  bits to emit
- START  in  1  request to serialize channel START_CH
- START_CH  in  CH_W  channel to serialize
- LOOP  in  1  repeat request (only with PATSER_LOOP_EN)
- BUSY  out  1  serialization in progress
- DONE  out  1  one-cycle pulse with the last bit
- ERR  out  1  one-cycle pulse on an invalid request
- signal_out  out  1  serial data, registered
- SIGNAL_VALID  out  1  signal_out carries a pattern bit

## Operation
- Reset: state IDLE; all outputs 0; pattern c = PAT_INIT slice; every length = PAT_W; shift register and counter 0.
- Write: WR_EN at an edge stores WR_DATA/WR_LEN into channel WR_CH, any state. WR_LEN 0 or >PAT_W stores PAT_W. WR_CH ≥ NUM_CH: no write, ERR pulse.
- FSM states IDLE, SHIFT.
- IDLE, START with START_CH < NUM_CH: load shift register with pattern << (PAT_W-LEN), counter = LEN, go to SHIFT.
- IDLE, START with START_CH ≥ NUM_CH: stay IDLE, ERR pulse.
- SHIFT, each edge:
  - signal_out ← shift MSB, SIGNAL_VALID ← 1
  - shift register shifts left with zero fill
  - counter decrements
  - counter==1: DONE ← 1, next state IDLE (or reload, see Configuration)
- START in SHIFT is ignored; no queue, no ERR.
- A write to the channel being shifted does not affect the shift in flight. It takes effect on the next START.
- Simultaneous WR_EN and START on the same channel: START loads the old contents.
- BUSY = (state==SHIFT).
- With SIGNAL_VALID low, signal_out is 0.

## Timing
- START accepted at edge k:
  - BUSY high after k
  - bits appear on signal_out/SIGNAL_VALID after edges k+1..k+LEN
  - DONE high with the last bit, after k+LEN
  - BUSY low after k+LEN
- Earliest next START is accepted at edge k+LEN+1, with its first bit after k+LEN+2. This leaves one idle cycle between patterns in one-shot mode.
- ERR and DONE are single-cycle registered pulses.
- RST assertion mid-shift aborts immediately: outputs 0, patterns restored to PAT_INIT.

## Configuration
- PATSER_LOOP_EN defined:
  - LOOP port present.
  - In SHIFT with counter==1 and LOOP=1: reload the same channel from the bank (including any writes made in the meantime), counter = LEN, stay SHIFT. The next bit follows gaplessly.
  - DONE still pulses at each pattern end; BUSY stays high.
  - LOOP=0 at the end finishes normally.
- Not defined: LOOP port absent; one-shot behaviour only.

## Structure
- Package patser_pkg holds:
  - the state enum (IDLE, SHIFT)
  - a clog2-with-min-1 function used for CH_W/CNT_W
  - the length-clamp function
- Sub-module patser_bank holds the NUM_CH pattern/length register file. It has a write port and a combinational read by channel.
- The FSM, counter, shift register and output registers stay in pattern_serializer.

## Test plan
- Reset with PAT_INIT ch0 = 88'h123456789ABCDEF1234567, START ch0 → 88 bits 0001_0010… MSB-first after edges 1..88; DONE at bit 88; BUSY high 88 cycles.
- Write ch1 = 16'hABCD, LEN=16; START ch1 → serial 1010101111001101, then SIGNAL_VALID=0, signal_out=0.
- WR_LEN=0 and WR_LEN=PAT_W+5 → both emit PAT_W bits; START_CH=NUM_CH → ERR pulse, BUSY stays 0.
- Write ch1 and START during an active ch1 shift → current stream unchanged, START ignored; the next START emits the new data.
- RST asserted at bit 5 of a 16-bit pattern → all outputs 0 in the same cycle; after release, START ch0 emits the PAT_INIT pattern.
- PATSER_LOOP_EN, ch2 = 4'b1001 LEN=4, LOOP=1 for 3 patterns → 100110011001 gapless, DONE every 4th cycle, BUSY low after the third.

Source files
------------

// File: rtl/pattern_serializer_pkg.sv
// Shared types and helpers for the pattern serializer.
// The optional PATSER_LOOP_EN feature does not change anything in this package.
package patser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Ceiling log2, never smaller than 1, so that single-channel builds still get a usable index.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Zero or oversize lengths fall back to the full pattern width.
    function automatic int clamp_len(input int len, input int pat_w);
        return ((len == 0) || (len > pat_w)) ? pat_w : len;
    endfunction

endpackage

// File: rtl/pattern_serializer_if.sv
// Control/status bundle between a pattern serializer and its driver.
// LOOP exists only when PATSER_LOOP_EN is defined.
interface pattern_serializer_if import patser_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int PAT_W  = 88
) ();
    localparam int CH_W  = clog2_min1(NUM_CH);
    localparam int CNT_W = clog2_min1(PAT_W + 1);

    logic             WR_EN;
    logic [CH_W-1:0]  WR_CH;
    logic [PAT_W-1:0] WR_DATA;
    logic [CNT_W-1:0] WR_LEN;
    logic             START;
    logic [CH_W-1:0]  START_CH;
`ifdef PATSER_LOOP_EN
    logic             LOOP;
`endif
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic             signal_out;
    logic             SIGNAL_VALID;

    modport master (
`ifdef PATSER_LOOP_EN
        output LOOP,
`endif
        output WR_EN, WR_CH, WR_DATA, WR_LEN, START, START_CH,
        input  BUSY, DONE, ERR, signal_out, SIGNAL_VALID
    );

    modport slave (
`ifdef PATSER_LOOP_EN
        input  LOOP,
`endif
        input  WR_EN, WR_CH, WR_DATA, WR_LEN, START, START_CH,
        output BUSY, DONE, ERR, signal_out, SIGNAL_VALID
    );

endinterface

// File: rtl/pattern_serializer_bank.sv
// Pattern/length register file: one synchronous write port, combinational read by channel.
// Unaffected by PATSER_LOOP_EN; the caller gates out-of-range write channels.
module patser_bank import patser_pkg::*; #(
    parameter int                      NUM_CH   = 4,
    parameter int                      PAT_W    = 88,
    parameter logic [NUM_CH*PAT_W-1:0] PAT_INIT = '0,
    parameter int                      CH_W     = 2,
    parameter int                      CNT_W    = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [PAT_W-1:0] wr_data,
    input  logic [CNT_W-1:0] wr_len,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [PAT_W-1:0] rd_pat,
    output logic [CNT_W-1:0] rd_len
);

    logic [PAT_W-1:0] pat_q [NUM_CH];
    logic [CNT_W-1:0] len_q [NUM_CH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pat_q[c] <= PAT_INIT[c*PAT_W +: PAT_W];
                len_q[c] <= CNT_W'(PAT_W);
            end
        end else if (wr_en) begin
            pat_q[wr_ch] <= wr_data;
            len_q[wr_ch] <= CNT_W'(clamp_len(int'(wr_len), PAT_W));
        end
    end

    assign rd_pat = pat_q[rd_ch];
    assign rd_len = len_q[rd_ch];

endmodule

// File: rtl/pattern_serializer.sv
// Multi-channel pattern serializer: shifts a stored pattern out MSB-first on a registered line.
// Define PATSER_LOOP_EN to enable gapless repetition controlled by the LOOP input.
//
//   state    | meaning
//   ST_IDLE  | waiting for START; output line held at 0
//   ST_SHIFT | emitting one pattern bit per clock, counter holds bits left
module pattern_serializer import patser_pkg::*; #(
    parameter int                      NUM_CH   = 4,
    parameter int                      PAT_W    = 88,
    parameter logic [NUM_CH*PAT_W-1:0] PAT_INIT = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    pattern_serializer_if.slave  bus
);

    localparam int CH_W  = clog2_min1(NUM_CH);
    localparam int CNT_W = clog2_min1(PAT_W + 1);

    state_e           state_q;
    logic [PAT_W-1:0] sreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sig_q;
    logic             valid_q;
    logic             done_q;
    logic             err_q;

    logic [CH_W-1:0]  rd_ch;
    logic [PAT_W-1:0] rd_pat;
    logic [CNT_W-1:0] rd_len;
    logic [PAT_W-1:0] load_val;
    logic             wr_ch_ok;
    logic             start_ch_ok;

    // Range checks only exist when the index width can address past the last channel.
    if ((1 << CH_W) > NUM_CH) begin : g_ch_partial
        assign wr_ch_ok    = (bus.WR_CH < CH_W'(NUM_CH));
        assign start_ch_ok = (bus.START_CH < CH_W'(NUM_CH));
    end else begin : g_ch_full
        assign wr_ch_ok    = 1'b1;
        assign start_ch_ok = 1'b1;
    end

`ifdef PATSER_LOOP_EN
    logic [CH_W-1:0] ch_q;
    assign rd_ch = (state_q == ST_SHIFT) ? ch_q : bus.START_CH;
`else
    assign rd_ch = bus.START_CH;
`endif

    patser_bank #(
        .NUM_CH   (NUM_CH),
        .PAT_W    (PAT_W),
        .PAT_INIT (PAT_INIT),
        .CH_W     (CH_W),
        .CNT_W    (CNT_W)
    ) u_bank (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (bus.WR_EN && wr_ch_ok),
        .wr_ch   (bus.WR_CH),
        .wr_data (bus.WR_DATA),
        .wr_len  (bus.WR_LEN),
        .rd_ch   (rd_ch),
        .rd_pat  (rd_pat),
        .rd_len  (rd_len)
    );

    // Left-justify so the first emitted bit (bit LEN-1) sits at the register MSB.
    assign load_val = rd_pat << (CNT_W'(PAT_W) - rd_len);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PATSER_LOOP_EN
            ch_q    <= '0;
`endif
        end else begin
            sig_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= bus.WR_EN && !wr_ch_ok;
            case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        if (start_ch_ok) begin
                            sreg_q  <= load_val;
                            cnt_q   <= rd_len;
                            state_q <= ST_SHIFT;
`ifdef PATSER_LOOP_EN
                            ch_q    <= bus.START_CH;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    sig_q   <= sreg_q[PAT_W-1];
                    valid_q <= 1'b1;
                    sreg_q  <= {sreg_q[PAT_W-2:0], 1'b0};
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_q <= 1'b1;
`ifdef PATSER_LOOP_EN
                        if (bus.LOOP) begin
                            sreg_q <= load_val;
                            cnt_q  <= rd_len;
                        end else begin
                            state_q <= ST_IDLE;
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.BUSY         = (state_q == ST_SHIFT);
    assign bus.DONE         = done_q;
    assign bus.ERR          = err_q;
    assign bus.signal_out   = sig_q;
    assign bus.SIGNAL_VALID = valid_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed/randomized bench for pattern_serializer against a bit-list reference model.
// Covers the loop feature when PATSER_LOOP_EN is defined.
module tb_pattern_serializer;
    import patser_pkg::*;

    localparam int NUM_CH = 3;
    localparam int PAT_W  = 88;
    localparam int CH_W   = clog2_min1(NUM_CH);
    localparam int CNT_W  = clog2_min1(PAT_W + 1);
    localparam logic [PAT_W-1:0] INIT0 = 88'h123456789ABCDEF1234567;
    localparam logic [PAT_W-1:0] INIT1 = 88'hC3A5_0F1E_2D3C_4B5A_6978_87;
    localparam logic [PAT_W-1:0] INIT2 = 88'h0;
    localparam logic [NUM_CH*PAT_W-1:0] INIT = {INIT2, INIT1, INIT0};

    logic CLK;
    logic RST;

    pattern_serializer_if #(.NUM_CH(NUM_CH), .PAT_W(PAT_W)) bus ();

    pattern_serializer #(
        .NUM_CH   (NUM_CH),
        .PAT_W    (PAT_W),
        .PAT_INIT (INIT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [PAT_W-1:0] m_pat [NUM_CH];
    int               m_len [NUM_CH];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus.BUSY, bus.DONE, bus.ERR, bus.SIGNAL_VALID, bus.signal_out};
    endfunction

    task automatic model_reset();
        logic [NUM_CH*PAT_W-1:0] img;
        img = INIT;
        for (int c = 0; c < NUM_CH; c++) begin
            m_pat[c] = img[c*PAT_W +: PAT_W];
            m_len[c] = PAT_W;
        end
    endtask

    task automatic model_write(input int ch, input logic [PAT_W-1:0] d, input int l);
        if (ch < NUM_CH) begin
            m_pat[ch] = d;
            m_len[ch] = ((l == 0) || (l > PAT_W)) ? PAT_W : l;
        end
    endtask

    task automatic write_ch(input int ch, input logic [PAT_W-1:0] d, input int l);
        bus.WR_EN   = 1'b1;
        bus.WR_CH   = CH_W'(ch);
        bus.WR_DATA = d;
        bus.WR_LEN  = CNT_W'(l);
        step();
        bus.WR_EN = 1'b0;
        model_write(ch, d, l);
        check($sformatf("write ch%0d err", ch), bus.ERR, (ch >= NUM_CH) ? 1'b1 : 1'b0);
    endtask

    // Runs one START on ch; optionally writes at the accepting edge or retries START mid-stream.
    task automatic run_pattern(input int ch, input int mid, input logic [PAT_W-1:0] nd,
                               input int nl, input bit wr_at_start, input string tag);
        bit exp_q[$];
        int len;
        len = m_len[ch];
        for (int i = len - 1; i >= 0; i--) exp_q.push_back(m_pat[ch][i]);
        bus.START    = 1'b1;
        bus.START_CH = CH_W'(ch);
        if (wr_at_start) begin
            bus.WR_EN   = 1'b1;
            bus.WR_CH   = CH_W'(ch);
            bus.WR_DATA = nd;
            bus.WR_LEN  = CNT_W'(nl);
        end
        step();
        if (wr_at_start) model_write(ch, nd, nl);
        bus.START = 1'b0;
        bus.WR_EN = 1'b0;
        check({tag, " accept"}, outs(), 5'b10000);
        for (int i = 0; i < len; i++) begin
            if (i == mid) begin
                bus.START   = 1'b1;
                bus.WR_EN   = 1'b1;
                bus.WR_CH   = CH_W'(ch);
                bus.WR_DATA = nd;
                bus.WR_LEN  = CNT_W'(nl);
            end
            step();
            if (i == mid) begin
                model_write(ch, nd, nl);
                bus.START = 1'b0;
                bus.WR_EN = 1'b0;
            end
            check($sformatf("%s bit%0d", tag, i), outs(),
                  {(i != len - 1), (i == len - 1), 1'b0, 1'b1, exp_q[i]});
        end
        step();
        check({tag, " idle"}, outs(), 5'b00000);
    endtask

    initial begin
        logic [95:0]      r96;
        logic [PAT_W-1:0] rd;
        int               rch;
        int               rl;

        RST          = 1'b1;
        bus.WR_EN    = 1'b0;
        bus.WR_CH    = '0;
        bus.WR_DATA  = '0;
        bus.WR_LEN   = '0;
        bus.START    = 1'b0;
        bus.START_CH = '0;
`ifdef PATSER_LOOP_EN
        bus.LOOP     = 1'b0;
`endif
        model_reset();
        step();
        step();
        check("reset outs", outs(), 5'b00000);
        RST = 1'b0;
        step();
        check("post-reset outs", outs(), 5'b00000);

        run_pattern(0, -1, '0, 0, 1'b0, "init ch0");

        write_ch(1, 88'hABCD, 16);
        run_pattern(1, -1, '0, 0, 1'b0, "ch1 abcd");

        write_ch(2, 88'hFEED_0000_0000_0000_0001, 0);
        run_pattern(2, -1, '0, 0, 1'b0, "len0");
        write_ch(2, 88'h8000_0000_0000_0000_00F0_0D, PAT_W + 5);
        run_pattern(2, -1, '0, 0, 1'b0, "len oversize");

        bus.START    = 1'b1;
        bus.START_CH = CH_W'(NUM_CH);
        step();
        bus.START = 1'b0;
        check("bad start pulse", outs(), 5'b00100);
        step();
        check("bad start clear", outs(), 5'b00000);
        write_ch(NUM_CH, 88'hDEAD, 8);
        step();
        check("bad write clear", outs(), 5'b00000);

        run_pattern(1, 6, 88'h5A3C, 16, 1'b0, "mid write");
        run_pattern(1, -1, '0, 0, 1'b0, "after mid write");
        run_pattern(1, -1, 88'h0F, 8, 1'b1, "same-edge write");
        run_pattern(1, -1, '0, 0, 1'b0, "after same-edge");

        for (int n = 0; n < 6; n++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            rd  = r96[PAT_W-1:0];
            rch = int'($urandom_range(0, NUM_CH - 1));
            rl  = int'($urandom_range(0, PAT_W + 10));
            write_ch(rch, rd, rl);
            run_pattern(rch, -1, '0, 0, 1'b0, $sformatf("rand%0d ch%0d", n, rch));
        end

        write_ch(1, 88'hB6D9, 16);
        bus.START    = 1'b1;
        bus.START_CH = CH_W'(1);
        step();
        bus.START = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre-abort busy", bus.BUSY, 1'b1);
        RST = 1'b1;
        #1;
        check("abort outs", outs(), 5'b00000);
        step();
        RST = 1'b0;
        model_reset();
        step();
        check("after abort outs", outs(), 5'b00000);
        run_pattern(0, -1, '0, 0, 1'b0, "restored ch0");
        run_pattern(1, -1, '0, 0, 1'b0, "restored ch1");

`ifdef PATSER_LOOP_EN
        write_ch(2, 88'b1001, 4);
        bus.LOOP     = 1'b1;
        bus.START    = 1'b1;
        bus.START_CH = CH_W'(2);
        step();
        bus.START = 1'b0;
        check("loop accept", outs(), 5'b10000);
        for (int i = 0; i < 12; i++) begin
            logic [3:0] pat;
            pat = 4'b1001;
            step();
            if (i == 7) bus.LOOP = 1'b0;
            check($sformatf("loop bit%0d", i), outs(),
                  {(i != 11), ((i % 4) == 3), 1'b0, 1'b1, pat[3 - (i % 4)]});
        end
        step();
        check("loop idle", outs(), 5'b00000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
